// File: rtl/irq_priority_controller_pkg.sv
// rtl/irq_priority_controller_pkg.sv - shared constants and FSM state type for the interrupt controller
package irq_pkg;

    localparam int N_IRQ_DEFAULT = 8;
    localparam int ID_W_DEFAULT  = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } irq_state_t;

endpackage

// File: rtl/irq_priority_controller_if.sv
// rtl/irq_priority_controller_if.sv - interrupt lines and core request/ack/eoi handshake bundle
interface irq_priority_controller_if
    import irq_pkg::*;
#(
    parameter int N_IRQ = N_IRQ_DEFAULT,
    parameter int ID_W  = ID_W_DEFAULT
);

    logic [N_IRQ-1:0] irq_in;
    logic [N_IRQ-1:0] irq_en;
    logic             irq_ack;
    logic             irq_eoi;
    logic             irq_req;
    logic [ID_W-1:0]  irq_id;
    logic             irq_active;
    logic [N_IRQ-1:0] irq_pending;

    // master: the controller; slave: the core and interrupt sources driving it
    modport master (
        input  irq_in, irq_en, irq_ack, irq_eoi,
        output irq_req, irq_id, irq_active, irq_pending
    );

    modport slave (
        output irq_in, irq_en, irq_ack, irq_eoi,
        input  irq_req, irq_id, irq_active, irq_pending
    );

endinterface

// File: rtl/irq_priority_select.sv
// rtl/irq_priority_select.sv - combinational highest-index priority encoder
module irq_priority_select #(
    parameter int N_IRQ = 8,
    parameter int ID_W  = 3
) (
    input  logic [N_IRQ-1:0] cand,
    output logic [ID_W-1:0]  sel,
    output logic             sel_valid
);

    // Ascending scan so the last hit, i.e. the highest index, wins
    always_comb begin
        sel = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (cand[i]) begin
                sel = ID_W'(i);
            end
        end
    end

    assign sel_valid = |cand;

endmodule

// File: rtl/irq_priority_controller.sv
// rtl/irq_priority_controller.sv - edge-captured, non-nesting priority interrupt controller
module irq_priority_controller
    import irq_pkg::*;
#(
    parameter int N_IRQ = N_IRQ_DEFAULT,
    parameter int ID_W  = ID_W_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    irq_priority_controller_if.master bus
);

    logic [N_IRQ-1:0] r_prev;
    logic [N_IRQ-1:0] r_pending;
    logic [N_IRQ-1:0] w_rise;
    logic [N_IRQ-1:0] w_clr;
    logic [N_IRQ-1:0] w_cand;
    logic [ID_W-1:0]  w_sel;
    logic             w_sel_valid;
    logic [ID_W-1:0]  r_id;
    logic             r_req;
    logic             r_active;
    irq_state_t       r_state;

    assign w_rise = bus.irq_in & ~r_prev;
    assign w_cand = r_pending & bus.irq_en;

    always_comb begin
        w_clr = '0;
        if (r_state == REQ && bus.irq_ack) begin
            w_clr[r_id] = 1'b1;
        end
    end

    irq_priority_select #(
        .N_IRQ (N_IRQ),
        .ID_W  (ID_W)
    ) u_select (
        .cand      (w_cand),
        .sel       (w_sel),
        .sel_valid (w_sel_valid)
    );

    // A fresh edge on the line being acked survives the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev    <= '0;
            r_pending <= '0;
        end else begin
            r_prev    <= bus.irq_in;
            r_pending <= (r_pending & ~w_clr) | w_rise;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_id     <= '0;
            r_req    <= 1'b0;
            r_active <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_sel_valid) begin
                        r_id    <= w_sel;
                        r_req   <= 1'b1;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    if (bus.irq_ack) begin
                        r_req    <= 1'b0;
                        r_active <= 1'b1;
                        r_state  <= SERVICE;
                    end
                end
                SERVICE: begin
                    if (bus.irq_eoi) begin
                        r_active <= 1'b0;
                        r_state  <= IDLE;
                    end
                end
                default: begin
                    r_req    <= 1'b0;
                    r_active <= 1'b0;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.irq_req     = r_req;
    assign bus.irq_id      = r_id;
    assign bus.irq_active  = r_active;
    assign bus.irq_pending = r_pending;

endmodule
